pwm_regs_mc: RTL and testbench
==============================

Name: pwm_regs_mc

Overview:
Parametrised multi-channel successor to the PWM register bank. It sits between the SPI decoder and the counter/pwm_gen instances, on the same 8-bit byte-addressed bus. It adds:
- configurable counter width and channel count;
- atomic multi-byte writes;
- double-buffered (shadow) period/compare/function registers, transferred on the counter's period boundary;
- coherent counter snapshot reads and registered read data.

Parameters:
NUM_CH, 4, number of PWM channels (1..8)
CNT_W, 16, counter/compare width in bits (8, 16, 24 or 32)

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
read  in  1  read strobe from decoder, 1 cycle
write  in  1  write strobe from decoder, 1 cycle
addr  in  8  {reg_index[5:0], byte_sel[1:0]}
data_write  in  8  write byte
data_read  out  8  registered read byte
counter_val  in  CNT_W  live counter value
update_evt  in  1  1-cycle pulse from counter at period wrap
period  out  CNT_W  active period
en  out  1  counter enable
count_reset  out  1  1-cycle counter reset pulse
upnotdown  out  1  1=up, 0=down
prescale  out  8  prescaler
pwm_en  out  NUM_CH  per-channel output enable
functions  out  2*NUM_CH  per-channel mode, ch n at [2n+1:2n]
compare1  out  NUM_CH*CNT_W  active compare1, ch n at [n*CNT_W +: CNT_W]
compare2  out  NUM_CH*CNT_W  active compare2, same packing
irq  out  1  interrupt (see Optional Feature)

Behaviour:

Reset (all outputs and internal state):
- All values 0, except upnotdown=1.
- This includes shadows, staging, pending flag, snapshot and data_read.

Register map (reg_index):
- 0x00 PERIOD: shadowed.
- 0x01 CTRL: b0 en, b1 upnotdown, b2 shadow_bypass. Direct, not shadowed.
- 0x02 PRESCALE: direct.
- 0x03 COUNT_RESET: write-only command.
- 0x04 COUNTER_VAL: read-only.
- 0x05 FORCE_UPDATE: write-only command.
- 0x06 STATUS, 0x07 IRQ_MASK: optional, see Optional Feature.
- 0x08+2n COMPARE1[n] and 0x09+2n COMPARE2[n]: shadowed.
- 0x20+n CHCFG[n]: b1:0 function, shadowed; b2 pwm_en, direct.
- Indices for n>=NUM_CH are unmapped.

Byte lanes (B = CNT_W/8, MS lane = B-1):
- Atomic multi-byte write: writing lanes 0..B-2 loads the shared staging register (CNT_W-8 bits), not the target.
- Writing lane B-1 commits {data_write, staging} to the target shadow in one cycle.
- For CNT_W=8, every write commits directly.
- Interleaving partial writes to different registers is unsupported; the commit uses current staging contents.
- Lanes >= B: writes ignored, reads return 0x00.
- 8-bit registers use lane 0 only.

Shadow transfer:
- Any shadow commit sets the pending flag.
- When pending=1, update_evt copies all shadows to active on the next clock edge and clears pending.
- shadow_bypass=1: commits write shadow and active in the same cycle; pending is not set.
- FORCE_UPDATE write: unconditional transfer on the next edge, clears pending.
- Commit and update_evt in the same cycle: the transfer uses the pre-commit shadow, and pending stays 1.

Command pulses:
- COUNT_RESET write: count_reset=1 for exactly the next cycle, then 0.
- Back-to-back writes give back-to-back pulses.

Reads (1-cycle latency):
- A read pulse at edge k presents data_read after edge k+1. The value holds until the next read.
- Unmapped index reads 0xFF.
- COUNTER_VAL lane 0 read returns counter_val[7:0] and captures the full counter_val into the snapshot. Higher lanes return snapshot bytes, so a lane0..laneB-1 read sequence is coherent.
- Shadowed registers read back the shadow value, not the active value.
- read and write in the same cycle: both take effect, and the read returns the pre-write value.

Optional Feature:
Macro PWM_REGS_IRQ_EN.

Defined:
- STATUS b0 UPD_DONE: set on every shadow→active transfer.
- STATUS b1 WRAP: set on every update_evt.
- STATUS is write-1-to-clear; set wins over clear in the same cycle.
- IRQ_MASK b1:0: read/write.
- irq is registered: irq = |(STATUS & IRQ_MASK).

Undefined:
- Indices 0x06/0x07 are unmapped (read 0xFF, writes ignored).
- irq is tied 0; the port stays present.

Test Plan:
- Reset → period=0, upnotdown=1, all compare/pwm_en/functions 0, data_read=0x00, count_reset=0.
- CNT_W=16, bypass=0: write COMPARE1[2] lane0=0x34, lane1=0x12 → compare1[2] unchanged. Read back 0x34/0x12. After update_evt pulse, compare1[2]=0x1234 one edge later.
- Write lane1 of PERIOD in the same cycle as update_evt → period keeps its old value. Next update_evt loads the new value. FORCE_UPDATE also loads it immediately.
- CTRL=0x04 (bypass): write PERIOD 0xCD then 0xAB → period=0xABCD the cycle after the second write; no update_evt needed.
- counter_val=0x1FF, read COUNTER_VAL lane0 → 0xFF. Change counter_val to 0x200, read lane1 → 0x01 (snapshot). Write COUNT_RESET → single 1-cycle pulse.
- PWM_REGS_IRQ_EN, mask=0x02: update_evt → STATUS=0x02 and irq=1. Write STATUS 0x02 in the same cycle as another update_evt → bit stays set. Clear in a later cycle → irq=0. Read index 0x2F with NUM_CH=4 → 0xFF.

Source files
------------

// File: rtl/pwm_regs_mc.sv
// pwm_regs_mc: multi-channel PWM register bank on an 8-bit byte-addressed bus.
// Sits between the SPI decoder and the counter/pwm_gen instances.
// Adds atomic multi-byte writes through a shared staging register, shadowed
// period/compare/function registers transferred on the counter period
// boundary, coherent counter snapshot reads and registered read data.
//
// Parameters:
//   NUM_CH  number of PWM channels (1..8)
//   CNT_W   counter/compare width in bits (8, 16, 24 or 32)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   read, write       1-cycle strobes from the decoder
//   addr              {reg_index[5:0], byte_sel[1:0]}
//   data_write        write byte
//   data_read         registered read byte (1-cycle latency, holds until next read)
//   counter_val       live counter value (snapshot source)
//   update_evt        1-cycle pulse from the counter at period wrap
//   period            active period
//   en, upnotdown     counter enable, count direction (1 = up)
//   count_reset       1-cycle counter reset pulse
//   prescale          prescaler
//   pwm_en            per-channel output enable
//   functions         per-channel mode, ch n at [2n+1:2n]
//   compare1/2        active compares, ch n at [n*CNT_W +: CNT_W]
//   irq               interrupt
//
// Optional feature macro: PWM_REGS_IRQ_EN
//   defined   -> STATUS (0x06, W1C) and IRQ_MASK (0x07) exist, irq = |(STATUS & IRQ_MASK)
//   undefined -> 0x06/0x07 unmapped, irq tied 0

module pwm_regs_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      read,
    input  logic                      write,
    input  logic [7:0]                addr,
    input  logic [7:0]                data_write,
    output logic [7:0]                data_read,
    input  logic [CNT_W-1:0]          counter_val,
    input  logic                      update_evt,
    output logic [CNT_W-1:0]          period,
    output logic                      en,
    output logic                      count_reset,
    output logic                      upnotdown,
    output logic [7:0]                prescale,
    output logic [NUM_CH-1:0]         pwm_en,
    output logic [2*NUM_CH-1:0]       functions,
    output logic [NUM_CH*CNT_W-1:0]   compare1,
    output logic [NUM_CH*CNT_W-1:0]   compare2,
    output logic                      irq
);

    localparam int unsigned NB    = CNT_W / 8;
    localparam int unsigned STG_W = (CNT_W > 8) ? CNT_W - 8 : 1;

    localparam logic [5:0] IDX_PERIOD      = 6'h00;
    localparam logic [5:0] IDX_CTRL        = 6'h01;
    localparam logic [5:0] IDX_PRESCALE    = 6'h02;
    localparam logic [5:0] IDX_COUNT_RESET = 6'h03;
    localparam logic [5:0] IDX_COUNTER     = 6'h04;
    localparam logic [5:0] IDX_FORCE       = 6'h05;
`ifdef PWM_REGS_IRQ_EN
    localparam logic [5:0] IDX_STATUS      = 6'h06;
    localparam logic [5:0] IDX_IRQ_MASK    = 6'h07;
`endif
    localparam logic [5:0] IDX_CMP_BASE    = 6'h08;
    localparam logic [5:0] IDX_CMP_END     = 6'(8 + 2 * NUM_CH);
    localparam logic [5:0] IDX_CHCFG_BASE  = 6'h20;
    localparam logic [5:0] IDX_CHCFG_END   = 6'(32 + NUM_CH);

    // Returns byte lane l of v, or 0x00 for lanes beyond the register width.
    function automatic logic [7:0] lane_byte(input logic [CNT_W-1:0] v, input logic [1:0] l);
        logic [7:0] r;
        r = 8'h00;
        for (int unsigned b = 0; b < NB; b++) begin
            if (l == 2'(b)) r = v[b*8 +: 8];
        end
        return r;
    endfunction

    // Address decode
    logic [5:0] idx;
    logic [1:0] lane;
    logic       lane0, lane_ms, lane_ok;
    logic       is_cmp, cmp_is2, is_chcfg, is_mb;
    logic [5:0] cmp_off;
    logic [2:0] cmp_ch, chcfg_ch;

    assign idx      = addr[7:2];
    assign lane     = addr[1:0];
    assign lane0    = (lane == 2'd0);
    assign lane_ms  = (lane == 2'(NB - 1));
    assign lane_ok  = ({1'b0, lane} < 3'(NB));
    assign is_cmp   = (idx >= IDX_CMP_BASE) && (idx < IDX_CMP_END);
    assign cmp_off  = idx - IDX_CMP_BASE;
    assign cmp_ch   = 3'(cmp_off >> 1);
    assign cmp_is2  = idx[0];
    assign is_chcfg = (idx >= IDX_CHCFG_BASE) && (idx < IDX_CHCFG_END);
    assign chcfg_ch = 3'(idx - IDX_CHCFG_BASE);
    assign is_mb    = (idx == IDX_PERIOD) || is_cmp;

    // Write qualifiers
    logic wr_stage, mb_commit, ch_commit, commit, force_upd, xfer;
    logic [CNT_W-1:0] commit_val;

    assign wr_stage  = write && is_mb && lane_ok && !lane_ms;
    assign mb_commit = write && is_mb && lane_ms;
    assign ch_commit = write && is_chcfg && lane0;
    assign commit    = mb_commit || ch_commit;
    assign force_upd = write && (idx == IDX_FORCE) && lane0;

    // Internal state
    logic                  bypass;
    logic                  pending;
    logic [CNT_W-1:0]      sh_period;
    logic [CNT_W-1:0]      sh_cmp1 [NUM_CH];
    logic [CNT_W-1:0]      sh_cmp2 [NUM_CH];
    logic [1:0]            sh_func [NUM_CH];
    logic [CNT_W-1:0]      snapshot;
    logic [7:0]            rd_mux;

    // Transfer happens on a pending period wrap or on an explicit force
    assign xfer = force_upd || (update_evt && pending);

    // Staging for the low lanes; the MS-lane write commits {data, staging}
    if (CNT_W > 8) begin : g_stage
        logic [STG_W-1:0] staging;

        always_ff @(posedge clk or negedge rst_n) begin : p_stage
            if (!rst_n) begin
                staging <= '0;
            end else if (wr_stage) begin
                for (int unsigned b = 0; b < NB - 1; b++) begin
                    if (lane == 2'(b)) staging[b*8 +: 8] <= data_write;
                end
            end
        end

        assign commit_val = {data_write, staging};
    end else begin : g_nostage
        logic unused_stage;
        assign unused_stage = wr_stage;
        assign commit_val   = data_write;
    end

    // Shadow/active registers, direct registers, pending flag and command pulse
    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            sh_period   <= '0;
            period      <= '0;
            compare1    <= '0;
            compare2    <= '0;
            functions   <= '0;
            pwm_en      <= '0;
            en          <= 1'b0;
            upnotdown   <= 1'b1;
            bypass      <= 1'b0;
            prescale    <= 8'h00;
            count_reset <= 1'b0;
            pending     <= 1'b0;
            snapshot    <= '0;
            data_read   <= 8'h00;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                sh_cmp1[i] <= '0;
                sh_cmp2[i] <= '0;
                sh_func[i] <= 2'b00;
            end
        end else begin
            // Transfer reads the pre-commit shadows; a bypass commit below overrides its target
            if (xfer) begin
                period <= sh_period;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    compare1[i*CNT_W +: CNT_W] <= sh_cmp1[i];
                    compare2[i*CNT_W +: CNT_W] <= sh_cmp2[i];
                    functions[2*i +: 2]        <= sh_func[i];
                end
            end

            if (mb_commit && (idx == IDX_PERIOD)) begin
                sh_period <= commit_val;
                if (bypass) period <= commit_val;
            end

            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (mb_commit && is_cmp && (cmp_ch == 3'(i))) begin
                    if (!cmp_is2) begin
                        sh_cmp1[i] <= commit_val;
                        if (bypass) compare1[i*CNT_W +: CNT_W] <= commit_val;
                    end else begin
                        sh_cmp2[i] <= commit_val;
                        if (bypass) compare2[i*CNT_W +: CNT_W] <= commit_val;
                    end
                end
                if (ch_commit && (chcfg_ch == 3'(i))) begin
                    sh_func[i] <= data_write[1:0];
                    pwm_en[i]  <= data_write[2];
                    if (bypass) functions[2*i +: 2] <= data_write[1:0];
                end
            end

            // A commit racing a transfer keeps the flag set for the next wrap
            if (commit && !bypass) begin
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end

            if (write && (idx == IDX_CTRL) && lane0) begin
                en        <= data_write[0];
                upnotdown <= data_write[1];
                bypass    <= data_write[2];
            end

            if (write && (idx == IDX_PRESCALE) && lane0) begin
                prescale <= data_write;
            end

            count_reset <= write && (idx == IDX_COUNT_RESET) && lane0;

            // Lane-0 counter read freezes the whole value for the higher lanes
            if (read && (idx == IDX_COUNTER) && lane0) begin
                snapshot <= counter_val;
            end

            if (read) begin
                data_read <= rd_mux;
            end
        end
    end

`ifdef PWM_REGS_IRQ_EN
    logic [1:0] status, irq_mask, status_n, mask_n;

    // STATUS W1C with set priority; irq follows the next-state so it aligns with STATUS
    always_comb begin : p_status_n
        status_n = status;
        mask_n   = irq_mask;
        if (write && lane0 && (idx == IDX_STATUS))   status_n = status & ~data_write[1:0];
        if (write && lane0 && (idx == IDX_IRQ_MASK)) mask_n   = data_write[1:0];
        status_n = status_n | {update_evt, xfer};
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_status
        if (!rst_n) begin
            status   <= 2'b00;
            irq_mask <= 2'b00;
            irq      <= 1'b0;
        end else begin
            status   <= status_n;
            irq_mask <= mask_n;
            irq      <= |(status_n & mask_n);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux; shadowed registers return the shadow value
    always_comb begin : p_rd_mux
        rd_mux = 8'hFF;
        case (idx)
            IDX_PERIOD:      rd_mux = lane_byte(sh_period, lane);
            IDX_CTRL:        rd_mux = lane0 ? {5'b0, bypass, upnotdown, en} : 8'h00;
            IDX_PRESCALE:    rd_mux = lane0 ? prescale : 8'h00;
            IDX_COUNT_RESET: rd_mux = 8'h00;
            IDX_FORCE:       rd_mux = 8'h00;
            IDX_COUNTER:     rd_mux = lane0 ? counter_val[7:0] : lane_byte(snapshot, lane);
`ifdef PWM_REGS_IRQ_EN
            IDX_STATUS:      rd_mux = lane0 ? {6'b0, status} : 8'h00;
            IDX_IRQ_MASK:    rd_mux = lane0 ? {6'b0, irq_mask} : 8'h00;
`endif
            default: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (is_cmp && (cmp_ch == 3'(i))) begin
                        rd_mux = lane_byte(cmp_is2 ? sh_cmp2[i] : sh_cmp1[i], lane);
                    end
                    if (is_chcfg && (chcfg_ch == 3'(i))) begin
                        rd_mux = lane0 ? {5'b0, pwm_en[i], sh_func[i]} : 8'h00;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// tb_pwm_regs_mc: directed test-plan sequences followed by random bus traffic,
// every cycle compared against a register-level reference model.

module tb_pwm_regs_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int B      = CNT_W / 8;
    localparam int NSLOT  = 2 * NUM_CH + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    read, write, update_evt;
    logic [7:0]              addr, data_write, data_read, prescale;
    logic [CNT_W-1:0]        counter_val, period;
    logic                    en, count_reset, upnotdown, irq;
    logic [NUM_CH-1:0]       pwm_en;
    logic [2*NUM_CH-1:0]     functions;
    logic [NUM_CH*CNT_W-1:0] compare1, compare2;

    int total = 0;
    int bad   = 0;

    pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
        .update_evt(update_evt), .period(period), .en(en), .count_reset(count_reset),
        .upnotdown(upnotdown), .prescale(prescale), .pwm_en(pwm_en),
        .functions(functions), .compare1(compare1), .compare2(compare2), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: slot 0 = PERIOD, slot 1+2n = COMPARE1[n], slot 2+2n = COMPARE2[n]
    logic [CNT_W-1:0] m_sh  [NSLOT];
    logic [CNT_W-1:0] m_act [NSLOT];
    logic [1:0]       m_fsh [NUM_CH];
    logic [1:0]       m_fact[NUM_CH];
    logic             m_pwm [NUM_CH];
    logic             m_en, m_ud, m_byp, m_pend, m_cres, m_irq;
    logic [7:0]       m_pre, m_dr;
    logic [CNT_W-1:0] m_stage, m_snap;
    logic [1:0]       m_st, m_mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(input int idx);
        if (idx == 0) return 0;
        if (idx >= 8 && idx < 8 + 2 * NUM_CH) return idx - 7;
        return -1;
    endfunction

    function automatic logic [7:0] m_read(input int idx, input int lane);
        int s;
        s = slot_of(idx);
        if (s >= 0) return (lane < B) ? m_sh[s][lane*8 +: 8] : 8'h00;
        if (idx >= 32 && idx < 32 + NUM_CH)
            return (lane == 0) ? {5'b0, m_pwm[idx-32], m_fsh[idx-32]} : 8'h00;
        case (idx)
            1: return (lane == 0) ? {5'b0, m_byp, m_ud, m_en} : 8'h00;
            2: return (lane == 0) ? m_pre : 8'h00;
            3, 5: return 8'h00;
            4: begin
                if (lane == 0) return counter_val[7:0];
                return (lane < B) ? m_snap[lane*8 +: 8] : 8'h00;
            end
`ifdef PWM_REGS_IRQ_EN
            6: return (lane == 0) ? {6'b0, m_st} : 8'h00;
            7: return (lane == 0) ? {6'b0, m_mask} : 8'h00;
`endif
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NSLOT; s++) begin
            m_sh[s]  = '0;
            m_act[s] = '0;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            m_fsh[n] = 2'b00; m_fact[n] = 2'b00; m_pwm[n] = 1'b0;
        end
        m_en = 0; m_ud = 1; m_byp = 0; m_pend = 0; m_cres = 0; m_irq = 0;
        m_pre = 0; m_dr = 0; m_stage = 0; m_snap = 0; m_st = 0; m_mask = 0;
    endtask

    task automatic model_step(input bit r, input bit w, input int idx, input int lane,
                              input logic [7:0] d, input bit evt);
        logic [7:0]       rdv;
        logic [CNT_W-1:0] val;
        bit               xfer, mb, chc, stg;
        int               s;
        rdv  = m_read(idx, lane);
        s    = slot_of(idx);
        mb   = w && (s >= 0) && (lane == B - 1);
        stg  = w && (s >= 0) && (lane < B - 1);
        chc  = w && (idx >= 32) && (idx < 32 + NUM_CH) && (lane == 0);
        xfer = (w && idx == 5 && lane == 0) || (evt && m_pend);
`ifdef PWM_REGS_IRQ_EN
        if (w && idx == 6 && lane == 0) m_st = m_st & ~d[1:0];
        if (w && idx == 7 && lane == 0) m_mask = d[1:0];
        m_st  = m_st | {evt, xfer};
        m_irq = |(m_st & m_mask);
`endif
        if (xfer) begin
            m_act  = m_sh;
            m_fact = m_fsh;
        end
        if (mb) begin
            val = m_stage;
            val[CNT_W-8 +: 8] = d;
            m_sh[s] = val;
            if (m_byp) m_act[s] = val;
        end
        if (stg) m_stage[lane*8 +: 8] = d;
        if (chc) begin
            m_fsh[idx-32] = d[1:0];
            m_pwm[idx-32] = d[2];
            if (m_byp) m_fact[idx-32] = d[1:0];
        end
        if ((mb || chc) && !m_byp) m_pend = 1;
        else if (xfer)             m_pend = 0;
        if (w && idx == 1 && lane == 0) {m_byp, m_ud, m_en} = d[2:0];
        if (w && idx == 2 && lane == 0) m_pre = d;
        m_cres = w && idx == 3 && lane == 0;
        if (r && idx == 4 && lane == 0) m_snap = counter_val;
        if (r) m_dr = rdv;
    endtask

    task automatic check_all();
        logic [NUM_CH*CNT_W-1:0] c1, c2;
        logic [2*NUM_CH-1:0]     f;
        logic [NUM_CH-1:0]       p;
        for (int n = 0; n < NUM_CH; n++) begin
            c1[n*CNT_W +: CNT_W] = m_act[1 + 2*n];
            c2[n*CNT_W +: CNT_W] = m_act[2 + 2*n];
            f[2*n +: 2]          = m_fact[n];
            p[n]                 = m_pwm[n];
        end
        check("data_read",   data_read,   m_dr);
        check("period",      period,      m_act[0]);
        check("compare1",    compare1,    c1);
        check("compare2",    compare2,    c2);
        check("functions",   functions,   f);
        check("pwm_en",      pwm_en,      p);
        check("en",          en,          m_en);
        check("upnotdown",   upnotdown,   m_ud);
        check("prescale",    prescale,    m_pre);
        check("count_reset", count_reset, m_cres);
        check("irq",         irq,         m_irq);
    endtask

    // One bus cycle: drive, let the DUT sample, advance the model, compare
    task automatic cycle(input bit r, input bit w, input int idx, input int lane,
                         input logic [7:0] d, input bit evt);
        read       = r;
        write      = w;
        addr       = {6'(idx), 2'(lane)};
        data_write = d;
        update_evt = evt;
        @(posedge clk);
        model_step(r, w, idx, lane, d, evt);
        #1;
        check_all();
        read = 0; write = 0; update_evt = 0;
    endtask

    task automatic wr(input int idx, input int lane, input logic [7:0] d, input bit evt = 0);
        cycle(0, 1, idx, lane, d, evt);
    endtask

    task automatic rd(input int idx, input int lane);
        cycle(1, 0, idx, lane, 8'h00, 0);
    endtask

    int idx_pool[25] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
                         32, 33, 34, 35, 36, 47, 24, 63};

    initial begin
        rst_n = 0; read = 0; write = 0; update_evt = 0;
        addr = 0; data_write = 0; counter_val = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_period",      period,      0);
        check("rst_upnotdown",   upnotdown,   1);
        check("rst_compare1",    compare1,    0);
        check("rst_compare2",    compare2,    0);
        check("rst_pwm_en",      pwm_en,      0);
        check("rst_functions",   functions,   0);
        check("rst_data_read",   data_read,   0);
        check("rst_count_reset", count_reset, 0);
        @(negedge clk);
        rst_n = 1;

        // Atomic COMPARE1[2] write, shadow readback, transfer on wrap
        wr(12, 0, 8'h34);
        wr(12, 1, 8'h12);
        check("cmp1_2_held", compare1[47:32], 16'h0000);
        rd(12, 0);
        check("cmp1_2_rd_l0", data_read, 8'h34);
        rd(12, 1);
        check("cmp1_2_rd_l1", data_read, 8'h12);
        cycle(0, 0, 0, 0, 8'h00, 1);
        check("cmp1_2_xfer", compare1[47:32], 16'h1234);

        // Commit racing update_evt: transfer uses old shadow, pending survives
        wr(0, 0, 8'h11);
        wr(0, 1, 8'h11);
        wr(0, 0, 8'h78);
        wr(0, 1, 8'h56, 1);
        check("period_race_old", period, 16'h1111);
        cycle(0, 0, 0, 0, 8'h00, 1);
        check("period_race_new", period, 16'h5678);
        wr(0, 0, 8'hBC);
        wr(0, 1, 8'h9A);
        check("period_pre_force", period, 16'h5678);
        wr(5, 0, 8'h00);
        check("period_force", period, 16'h9ABC);

        // Shadow bypass
        wr(1, 0, 8'h04);
        wr(0, 0, 8'hCD);
        wr(0, 1, 8'hAB);
        check("period_bypass", period, 16'hABCD);
        wr(1, 0, 8'h03);
        check("ctrl_en", en, 1);

        // Coherent counter snapshot and count_reset pulse
        counter_val = 16'h01FF;
        rd(4, 0);
        check("cnt_l0", data_read, 8'hFF);
        counter_val = 16'h0200;
        rd(4, 1);
        check("cnt_l1_snap", data_read, 8'h01);
        wr(3, 0, 8'h00);
        check("cres_pulse", count_reset, 1);
        cycle(0, 0, 0, 0, 8'h00, 0);
        check("cres_low", count_reset, 0);
        wr(3, 0, 8'h00);
        wr(3, 0, 8'h00);
        check("cres_b2b", count_reset, 1);

        // Unmapped index and out-of-range lane
        rd(47, 0);
        check("unmapped_2f", data_read, 8'hFF);
        rd(0, 2);
        check("lane_oob", data_read, 8'h00);

`ifdef PWM_REGS_IRQ_EN
        wr(6, 0, 8'h03);
        wr(7, 0, 8'h02);
        cycle(0, 0, 0, 0, 8'h00, 1);
        check("irq_set", irq, 1);
        rd(6, 0);
        check("status_wrap", data_read, 8'h02);
        wr(6, 0, 8'h02, 1);
        rd(6, 0);
        check("status_set_wins", data_read, 8'h02);
        wr(6, 0, 8'h02);
        check("irq_clr", irq, 0);
`else
        rd(6, 0);
        check("status_unmapped", data_read, 8'hFF);
        cycle(0, 0, 0, 0, 8'h00, 1);
        check("irq_tied", irq, 0);
`endif

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            counter_val = CNT_W'($urandom);
            cycle(($urandom % 3) == 0, ($urandom % 2) == 0,
                  idx_pool[$urandom % 25], int'($urandom % 4),
                  8'($urandom), ($urandom % 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
